// File: rtl/dump_engine.sv
// dump_engine: sends an 11-byte header followed by circular-buffer samples to a byte-wide UART.
// Optional feature: define DUMP_CRC_EN to append a CRC-8 byte after the payload.
`ifndef AW
`define AW 10
`endif
`ifndef PRE_SAMP
`define PRE_SAMP 16'd256
`endif
`ifndef POST_SAMP
`define POST_SAMP 16'd768
`endif
`ifndef HDR0
`define HDR0 8'hA5
`endif
`ifndef HDR1
`define HDR1 8'h5A
`endif
`ifndef VERSION
`define VERSION 8'h01
`endif

module dump_engine #(
  parameter int          AW   = `AW,
  parameter int          SW   = 1,
  parameter logic [15:0] PRE  = `PRE_SAMP,
  parameter logic [15:0] POST = `POST_SAMP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_dump,
  input  logic            abort,
  input  logic [AW-1:0]   start_addr,
  input  logic [15:0]     count,
  input  logic [7:0]      chan_mask,
  output logic [AW-1:0]   raddr,
  input  logic [8*SW-1:0] rdata,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_busy,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_LOAD,
    S_PAY,
    S_DONE
`ifdef DUMP_CRC_EN
    , S_CRC
`endif
  } state_t;

  state_t          state_q;
  logic [3:0]      idx_q;
  logic [1:0]      bidx_q;
  logic [15:0]     rem_q;
  logic [15:0]     count_q;
  logic [7:0]      mask_q;
  logic [8*SW-1:0] sample_q;
  logic [AW-1:0]   raddr_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            busy_q;
  logic            done_q;

  logic [7:0] hdr_byte;
  logic [7:0] out_byte;
  logic       can_send;
  logic       last_hdr;
  logic       last_byte;

  // A byte may only go out when the UART is idle and the previous cycle was not a strobe.
  assign can_send  = !tx_start_q && !tx_busy;
  assign last_hdr  = (idx_q == 4'd10);
  assign last_byte = (bidx_q == 2'(SW - 1));

  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      4'd0:    hdr_byte = `HDR0;
      4'd1:    hdr_byte = `HDR1;
      4'd2:    hdr_byte = `VERSION;
      4'd3:    hdr_byte = mask_q;
      4'd4:    hdr_byte = 8'(SW);
      4'd5:    hdr_byte = PRE[7:0];
      4'd6:    hdr_byte = PRE[15:8];
      4'd7:    hdr_byte = POST[7:0];
      4'd8:    hdr_byte = POST[15:8];
      4'd9:    hdr_byte = count_q[7:0];
      4'd10:   hdr_byte = count_q[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end

`ifdef DUMP_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_d;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    out_byte = hdr_byte;
    if (state_q == S_PAY) out_byte = sample_q[7:0];
    if (state_q == S_CRC) out_byte = crc_q;
    crc_d = crc8_upd(crc_q, out_byte);
  end
`else
  always_comb begin
    out_byte = hdr_byte;
    if (state_q == S_PAY) out_byte = sample_q[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      bidx_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      mask_q     <= '0;
      sample_q   <= '0;
      raddr_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        idx_q   <= '0;
        bidx_q  <= '0;
        rem_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_dump) begin
              state_q <= S_HDR;
              busy_q  <= 1'b1;
              raddr_q <= start_addr;
              count_q <= count;
              rem_q   <= count;
              mask_q  <= chan_mask;
              idx_q   <= '0;
              bidx_q  <= '0;
`ifdef DUMP_CRC_EN
              crc_q   <= '0;
`endif
            end
          end
          S_HDR: begin
            if (can_send) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= out_byte;
`ifdef DUMP_CRC_EN
              // Sync bytes are excluded from the checksum.
              if (idx_q >= 4'd2) crc_q <= crc_d;
`endif
              if (last_hdr) begin
                idx_q <= '0;
                if (rem_q != 16'd0) begin
                  state_q <= S_FETCH;
                end else begin
`ifdef DUMP_CRC_EN
                  state_q <= S_CRC;
`else
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            sample_q <= rdata;
            rem_q    <= rem_q - 16'd1;
            bidx_q   <= '0;
            state_q  <= S_PAY;
          end
          S_PAY: begin
            if (can_send) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= out_byte;
              sample_q   <= sample_q >> 8;
`ifdef DUMP_CRC_EN
              crc_q      <= crc_d;
`endif
              if (last_byte) begin
                if (rem_q != 16'd0) begin
                  raddr_q <= raddr_q + 1'b1;
                  state_q <= S_FETCH;
                end else begin
`ifdef DUMP_CRC_EN
                  state_q <= S_CRC;
`else
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
                end
              end else begin
                bidx_q <= bidx_q + 2'd1;
              end
            end
          end
`ifdef DUMP_CRC_EN
          S_CRC: begin
            if (can_send) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= out_byte;
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
`endif
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign raddr    = raddr_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dump_engine.sv
// tb_dump_engine: directed vectors for dump_engine with a registered-read buffer and a simple UART model.
`timescale 1ns/1ps
`ifndef HDR0
`define HDR0 8'hA5
`endif
`ifndef HDR1
`define HDR1 8'h5A
`endif
`ifndef VERSION
`define VERSION 8'h01
`endif

module tb_dump_engine;
  localparam int AW = 4;
  localparam int SW = 2;
  localparam logic [15:0] PRE  = 16'h0140;
  localparam logic [15:0] POST = 16'h02C0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_dump = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   count = '0;
  logic [7:0]    chan_mask = '0;
  logic [AW-1:0] raddr;
  logic [15:0]   rdata = '0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          busy;
  logic          done;

  dump_engine #(.AW(AW), .SW(SW), .PRE(PRE), .POST(POST)) dut (
    .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .abort(abort),
    .start_addr(start_addr), .count(count), .chan_mask(chan_mask),
    .raddr(raddr), .rdata(rdata), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) rdata <= mem[raddr];

  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor: only appends / increments, so tests work from snapshots.
  logic [7:0]    rx_q [$];
  int            stamp_q [$];
  logic [AW-1:0] rlog_q [$];
  int            cyc = 0, done_cnt = 0, viol = 0;
  logic          prev_start = 1'b0, prev_busy = 1'b0;
  logic [AW-1:0] prev_raddr = '0;
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      rx_q.push_back(tx_data);
      stamp_q.push_back(cyc);
      if (tx_busy) viol++;
      if (prev_start) viol++;
    end
    prev_start = tx_start;
    if (done) begin
      done_cnt++;
      if (busy) viol++;
    end
    if (busy && (!prev_busy || raddr != prev_raddr)) rlog_q.push_back(raddr);
    prev_busy  = busy;
    prev_raddr = raddr;
  end

  int tests = 0, failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] cnt;
    logic [7:0]  mask;
    int          blen;
    bit          poke;
    bit          abort_start;
  } vec_t;

  vec_t vecs [6];
  int   last_rb = 0;

  task automatic run_dump(input vec_t v, input int k);
    logic [7:0]    exp [$];
    logic [15:0]   w;
    logic [AW-1:0] ea;
    logic [7:0]    c;
    int rb, sb, db, lb, vb, n, got, lim;
    exp.push_back(`HDR0); exp.push_back(`HDR1); exp.push_back(`VERSION);
    exp.push_back(v.mask); exp.push_back(8'd2);
    exp.push_back(PRE[7:0]); exp.push_back(PRE[15:8]);
    exp.push_back(POST[7:0]); exp.push_back(POST[15:8]);
    exp.push_back(v.cnt[7:0]); exp.push_back(v.cnt[15:8]);
    for (int i = 0; i < int'(v.cnt); i++) begin
      ea = v.addr + 4'(i);
      w  = mem[ea];
      exp.push_back(w[7:0]);
      exp.push_back(w[15:8]);
    end
`ifdef DUMP_CRC_EN
    c = 8'h00;
    for (int i = 2; i < exp.size(); i++) c = crc8(c, exp[i]);
    exp.push_back(c);
`else
    c = 8'h00;
`endif
    rb = rx_q.size(); sb = stamp_q.size(); db = done_cnt; lb = rlog_q.size(); vb = viol;
    last_rb = rb;
    busy_len = v.blen;
    start_addr = v.addr; count = v.cnt; chan_mask = v.mask;
    start_dump = 1'b1;
    abort = v.abort_start;
    check($sformatf("v%0d busy_before_start", k), {31'd0, busy}, 32'd0);
    tick();
    start_dump = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d busy_rise", k), {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      start_dump = (v.poke && n == 6);
      if (v.poke && n == 6) begin start_addr = 4'h0; count = 16'd1; end
      tick();
      n++;
    end
    start_dump = 1'b0;
    check($sformatf("v%0d done_within_bound", k), {31'd0, (n < 4000)}, 32'd1);
    if (v.poke) begin
      start_addr = 4'h0; count = 16'd1; start_dump = 1'b1;
      tick();
      start_dump = 1'b0;
      check($sformatf("v%0d start_in_done_ignored", k), {31'd0, busy}, 32'd0);
    end
    repeat (v.blen + 6) tick();
    got = rx_q.size() - rb;
    check($sformatf("v%0d byte_count", k), got, exp.size());
    lim = (got < exp.size()) ? got : exp.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("v%0d byte[%0d]", k, i), {24'd0, rx_q[rb + i]}, {24'd0, exp[i]});
    check($sformatf("v%0d done_pulses", k), done_cnt - db, 32'd1);
    check($sformatf("v%0d protocol_violations", k), viol - vb, 32'd0);
    check($sformatf("v%0d raddr_log_len", k), rlog_q.size() - lb, (v.cnt == 0) ? 32'd1 : {16'd0, v.cnt});
    for (int i = 0; i < int'(v.cnt) && (lb + i) < rlog_q.size(); i++)
      check($sformatf("v%0d raddr[%0d]", k, i), {28'd0, rlog_q[lb + i]}, {28'd0, v.addr + 4'(i)});
    if (v.blen == 0 && (stamp_q.size() - sb) >= 11)
      check($sformatf("v%0d header_strobe_span", k), stamp_q[sb + 10] - stamp_q[sb], 32'd20);
    $display("[TB] vector %0d addr=%0h count=%0d bytes=%0d crc=%02h", k, v.addr, v.cnt, got, c);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rb, db, nb, n;
    for (int i = 0; i < 16; i++) mem[i] = {4'(i), 4'hC, 4'(15 - i), 4'(i)};
    mem[5] = 16'hBEEF;
    mem[6] = 16'h1234;

    vecs[0] = '{addr: 4'hA, cnt: 16'd3, mask: 8'hFF, blen: 0,  poke: 1'b0, abort_start: 1'b0};
    vecs[1] = '{addr: 4'h5, cnt: 16'd2, mask: 8'h5A, blen: 0,  poke: 1'b0, abort_start: 1'b0};
    vecs[2] = '{addr: 4'hE, cnt: 16'd4, mask: 8'h0F, blen: 0,  poke: 1'b0, abort_start: 1'b1};
    vecs[3] = '{addr: 4'h3, cnt: 16'd0, mask: 8'h81, blen: 0,  poke: 1'b0, abort_start: 1'b0};
    vecs[4] = '{addr: 4'hE, cnt: 16'd3, mask: 8'h3C, blen: 20, poke: 1'b0, abort_start: 1'b0};
    vecs[5] = '{addr: 4'h1, cnt: 16'd2, mask: 8'hC3, blen: 0,  poke: 1'b1, abort_start: 1'b0};

    repeat (3) tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset tx_start", {31'd0, tx_start}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);
    check("reset raddr", {28'd0, raddr}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_dump(vecs[k], k);
      if (k == 1) begin
        check("sample BEEF lo", {24'd0, rx_q[last_rb + 11]}, 32'hEF);
        check("sample BEEF hi", {24'd0, rx_q[last_rb + 12]}, 32'hBE);
        check("sample 1234 lo", {24'd0, rx_q[last_rb + 13]}, 32'h34);
        check("sample 1234 hi", {24'd0, rx_q[last_rb + 14]}, 32'h12);
      end
    end

    // Abort after the second payload byte of an 8-sample dump.
    busy_len = 0;
    rb = rx_q.size(); db = done_cnt;
    start_addr = 4'h2; count = 16'd8; chan_mask = 8'h11; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    n = 0;
    while ((rx_q.size() - rb) < 13 && n < 1000) begin tick(); n++; end
    check("abort reach payload byte 2", {31'd0, (n < 1000)}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy low", {31'd0, busy}, 32'd0);
    nb = rx_q.size();
    check("abort bytes sent", nb - rb, 32'd13);
    repeat (40) tick();
    check("abort no further strobes", rx_q.size(), nb);
    check("abort no done", done_cnt, db);
    $display("[TB] abort sequence bytes=%0d", nb - rb);

    // Reset in the middle of a new header.
    rb = rx_q.size(); db = done_cnt;
    start_addr = 4'h4; count = 16'd5; chan_mask = 8'h22; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    n = 0;
    while ((rx_q.size() - rb) < 5 && n < 200) begin tick(); n++; end
    check("reset reach header byte 5", {31'd0, (n < 200)}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset tx_start", {31'd0, tx_start}, 32'd0);
    check("midreset tx_data", {24'd0, tx_data}, 32'd0);
    check("midreset raddr", {28'd0, raddr}, 32'd0);
    nb = rx_q.size();
    repeat (10) tick();
    check("midreset no strobes", rx_q.size(), nb);
    check("midreset no done", done_cnt, db);
    $display("[TB] reset sequence bytes_before_reset=%0d", nb - rb);
    rst_n = 1'b1;
    run_dump(vecs[0], 6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
